sha_seq_ctrl: RTL and testbench

SHA_SEQ_CTRL -- requirements
Module: sha_seq_ctrl

---
 rtl/bitcoin_pkg.sv | 47 ++++
 rtl/sha_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_sha_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin miner: datapath state codes, sequencer
// states and SHA-256 constants.
package bitcoin_pkg;

  localparam int ROUNDS       = 64;
  localparam int HEADER_WORDS = 20;

  localparam logic [31:0] SHA_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // State codes seen by the sha256 datapath.
  typedef enum logic [3:0] {
    SHA_IDLE    = 4'd0,
    SHA_READ1   = 4'd1,
    SHA_READ2   = 4'd2,
    SHA_PRECOMP = 4'd3,
    SHA_PHASE1  = 4'd4,
    SHA_PHASE2  = 4'd5,
    SHA_PHASE3  = 4'd6,
    SHA_COMPUTE = 4'd7,
    SHA_WRITE   = 4'd8
  } sha_state_e;

  // Internal sequencer states; COMPUTE is split so each knows which phase follows.
  typedef enum logic [3:0] {
    S_IDLE, S_READ1, S_READ2, S_PRECOMP,
    S_PHASE1, S_COMP1, S_PHASE2, S_COMP2,
    S_PHASE3, S_COMP3, S_WRITE
  } seq_state_e;

  function automatic sha_state_e toShaState(seq_state_e s);
    case (s)
      S_READ1:                   return SHA_READ1;
      S_READ2:                   return SHA_READ2;
      S_PRECOMP:                 return SHA_PRECOMP;
      S_PHASE1:                  return SHA_PHASE1;
      S_PHASE2:                  return SHA_PHASE2;
      S_PHASE3:                  return SHA_PHASE3;
      S_COMP1, S_COMP2, S_COMP3: return SHA_COMPUTE;
      S_WRITE:                   return SHA_WRITE;
      default:                   return SHA_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sha_seq_ctrl.sv
// Job sequencer for the sha256 datapath: walks each nonce through the
// read/phase/compute/write sequence and stores one result word per nonce.
module sha_seq_ctrl #(
  parameter int NUM_NONCES = 16,
  parameter int ROUNDS     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] hashout,
  output logic [3:0]  sha_state,
  output logic        sha_start,
  output logic [31:0] sha_rand_num,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_write_data,
  output logic        busy,
  output logic        done
);
  import bitcoin_pkg::*;

  localparam int             CW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(ROUNDS - 1);
  localparam logic [7:0]     N_LAST   = 8'(NUM_NONCES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    n_q, n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   memAddr_q, memAddr_d;

  // Address is registered from the next state so that reset can hold it at zero.
  function automatic logic [15:0] nextAddr(seq_state_e s, logic [CW-1:0] k,
                                           logic [7:0] n);
    logic [15:0] k16;
    logic [15:0] off;
    k16 = 16'(k);
    off = (k16 < 16'd12) ? k16 + 16'd3 : 16'd15;
    case (s)
      S_READ2:   nextAddr = message_addr + 16'd1;
      S_PRECOMP: nextAddr = message_addr + 16'd2;
      S_PHASE1:  nextAddr = message_addr + off;
      S_COMP1:   nextAddr = message_addr + 16'd16;
      S_PHASE2:  nextAddr = message_addr + 16'd17;
      S_WRITE:   nextAddr = output_addr + {8'd0, n};
      default:   nextAddr = message_addr;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      memAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      memAddr_q <= memAddr_d;
    end
  end

  // The counter is zero outside the phases, so every phase entry starts at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          state_d = S_READ1;
        end else if (start) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          n_d    = '0;
        end
      end
      S_READ1:   state_d = S_READ2;
      S_READ2:   state_d = S_PRECOMP;
      S_PRECOMP: state_d = S_PHASE1;
      S_PHASE1: begin
        if (cnt_q == CNT_LAST) state_d = S_COMP1;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_COMP1: state_d = S_PHASE2;
      S_PHASE2: begin
        if (cnt_q == CNT_LAST) state_d = S_COMP2;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_COMP2: state_d = S_PHASE3;
      S_PHASE3: begin
        if (cnt_q == CNT_LAST) state_d = S_COMP3;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_COMP3: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_IDLE;
        if (n_q == N_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          n_d = n_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    memAddr_d = nextAddr(state_d, cnt_d, n_d);
  end

  assign sha_state      = toShaState(state_q);
  assign sha_start      = busy_q && (state_q == S_IDLE);
  assign sha_rand_num   = {24'd0, n_q};
  assign mem_addr       = memAddr_q;
  assign mem_we         = (state_q == S_WRITE);
  assign mem_write_data = mem_we ? hashout : 32'd0;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sha_seq_ctrl.sv
// Self-checking bench for sha_seq_ctrl: cycle-accurate sequence model plus a
// write scoreboard filled when a job is started.
module tb_sha_seq_ctrl;

  localparam int NN  = 16;
  localparam int RR  = 64;
  localparam int SEQ = 8 + 3 * RR;
  localparam logic [31:0] HMASK = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = 16'h0;
  logic [15:0] output_addr = 16'h0;
  logic [31:0] hashout;
  logic [3:0]  sha_state;
  logic        sha_start;
  logic [31:0] sha_rand_num;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic        busy;
  logic        done;

  sha_seq_ctrl #(.NUM_NONCES(NN), .ROUNDS(RR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .message_addr(message_addr), .output_addr(output_addr), .hashout(hashout),
    .sha_state(sha_state), .sha_start(sha_start), .sha_rand_num(sha_rand_num),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .busy(busy), .done(done)
  );

  // Stand-in datapath: result word derived from the nonce it is working on.
  assign hashout = sha_rand_num ^ HMASK;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;
  wr_t sbq[$];

  int          checks = 0;
  int          errors = 0;
  bit          active = 1'b0;
  int          acc = 0;
  logic [15:0] mAddr = 16'h0;
  logic [15:0] oAddr = 16'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] expState(int u);
    if (u <= 3)             return 4'(u);
    if (u < 4 + RR)         return 4'd4;
    if (u == 4 + RR)        return 4'd7;
    if (u < 5 + 2 * RR)     return 4'd5;
    if (u == 5 + 2 * RR)    return 4'd7;
    if (u < 6 + 3 * RR)     return 4'd6;
    if (u == 6 + 3 * RR)    return 4'd7;
    return 4'd8;
  endfunction

  function automatic logic [15:0] expAddr(int u, int n);
    int k;
    if (u <= 1)          return mAddr;
    if (u == 2)          return mAddr + 16'd1;
    if (u == 3)          return mAddr + 16'd2;
    if (u < 4 + RR) begin
      k = u - 4 + 3;
      if (k > 15) k = 15;
      return mAddr + 16'(k);
    end
    if (u == 4 + RR)     return mAddr + 16'd16;
    if (u < 5 + 2 * RR)  return mAddr + 16'd17;
    if (u == SEQ - 1)    return oAddr + 16'(n);
    return mAddr;
  endfunction

  // Per-cycle model comparison while a job runs; scoreboard pop on every write.
  always @(negedge clk) begin : monitor
    int  t, u, n;
    wr_t w;
    if (reset_n) begin
      if (active) begin
        t = cyc - acc;
        if (t < NN * SEQ) begin
          u = t % SEQ;
          n = t / SEQ;
          checkOutput("state", 32'(sha_state), 32'(expState(u)));
          checkOutput("addr", 32'(mem_addr), 32'(expAddr(u, n)));
          checkOutput("ctl", 32'({busy, done, sha_start, mem_we}),
                      32'({1'b1, 1'b0, u == 0, u == SEQ - 1}));
          checkOutput("nonce", sha_rand_num, 32'(n));
          checkOutput("wdata", mem_write_data, (u == SEQ - 1) ? (32'(n) ^ HMASK) : 32'd0);
        end else begin
          checkOutput("jobDone", 32'({busy, done, sha_state}), 32'({1'b0, 1'b1, 4'd0}));
          active = 1'b0;
        end
      end else begin
        checkOutput("idleStart", 32'(sha_start), 32'd0);
      end
      if (mem_we) begin
        if (sbq.size() == 0) begin
          checkOutput("spuriousWe", 32'(mem_we), 32'd0);
        end else begin
          w = sbq.pop_front();
          checkOutput("wrAddr", 32'(mem_addr), 32'(w.addr));
          checkOutput("wrData", mem_write_data, w.data);
          checkOutput("wrCycle", 32'(cyc), 32'(w.at));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] ma, input logic [15:0] oa);
    wr_t w;
    @(negedge clk);
    message_addr = ma;
    output_addr  = oa;
    mAddr        = ma;
    oAddr        = oa;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc   = cyc;
    for (int i = 0; i < NN; i++) begin
      w.addr = oa + 16'(i);
      w.data = 32'(i) ^ HMASK;
      w.at   = acc + i * SEQ + SEQ - 1;
      sbq.push_back(w);
    end
    active = 1'b1;
  endtask

  task automatic waitOffset(input int off);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cyc - acc != off) && (k < 5000));
    checkOutput("reachOffset", 32'(cyc - acc), 32'(off));
  endtask

  task automatic waitIdle();
    int k = 0;
    while (active && (k < NN * SEQ + 50)) begin
      @(negedge clk);
      k++;
    end
    #1;
    checkOutput("jobEnded", 32'(active), 32'd0);
    active = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "State"}, 32'(sha_state), 32'd0);
    checkOutput({tag, "Start"}, 32'(sha_start), 32'd0);
    checkOutput({tag, "Nonce"}, sha_rand_num, 32'd0);
    checkOutput({tag, "Addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "We"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "Wdata"}, mem_write_data, 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
  endtask

  initial begin
    message_addr = 16'h1234;
    output_addr  = 16'h5678;
    #2;
    checkResetOutputs("rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idleAfterRst", 32'({busy, done}), 32'd0);

    // Full job with a mid-job re-pulse, and start coinciding with done rising.
    applyStimulus(16'h0100, 16'h0000);
    repeat (1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitOffset(NN * SEQ - 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("doneHold", 32'({busy, done}), 32'b01);
    end

    // Wrapping header reads and result writes.
    applyStimulus(16'hFFF8, 16'hFFFE);
    waitIdle();

    // Reset mid-job abandons everything.
    applyStimulus(16'h0200, 16'h0040);
    waitOffset(150);
    #2;
    reset_n = 1'b0;
    active  = 1'b0;
    sbq.delete();
    #1;
    checkResetOutputs("midRst");
    repeat (3) @(negedge clk);
    checkOutput("rstHoldWe", 32'(mem_we), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("postRstIdle", 32'({busy, done, sha_state}), 32'd0);

    // Fresh job after reset.
    applyStimulus(16'h0000, 16'h0010);
    waitIdle();
    checkOutput("sbDrained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
